// File: rtl/multi_buffer_controller_if.sv
// Handshake bundle between the frame-store arbiter and its camera writer / display reader.
// The client side drives requests and finalize pulses; the arbiter drives grants and status.
interface multi_buffer_controller_if #(
  parameter int ID_WIDTH = 2
);
  logic                write_rq_rdy;
  logic                finalize_wr;
  logic                read_rq_rdy;
  logic                finalize_rd;
  logic                wr_id_valid;
  logic [ID_WIDTH-1:0] wr_id;
  logic                rd_id_valid;
  logic [ID_WIDTH-1:0] rd_id;
  logic [ID_WIDTH:0]   ready_count;
  logic                frame_dropped;
  logic                protocol_error;

  modport master (
    output write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
    input  wr_id_valid, wr_id, rd_id_valid, rd_id, ready_count, frame_dropped, protocol_error
  );

  modport slave (
    input  write_rq_rdy, finalize_wr, read_rq_rdy, finalize_rd,
    output wr_id_valid, wr_id, rd_id_valid, rd_id, ready_count, frame_dropped, protocol_error
  );
endinterface

// File: rtl/multi_buffer_controller.sv
// N-buffer frame-store arbiter: one writer, one reader, per-buffer FREE/WRITING/READY/READING
// tracking and a completion-ordered ready queue; optional reclaim of the oldest frame when full.
module multi_buffer_controller #(
  parameter int NUM_BUFFERS  = 3,
  parameter int ID_WIDTH     = $clog2(NUM_BUFFERS),
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_buffer_controller_if.slave bus
);
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [ID_WIDTH:0]   cnt_t;

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_WRITING = 2'd1;
  localparam logic [1:0] B_READY   = 2'd2;
  localparam logic [1:0] B_READING = 2'd3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_GRANT = 2'd1;
  localparam logic [1:0] W_HOLD  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_GRANT = 2'd1;
  localparam logic [1:0] R_HOLD  = 2'd2;

  localparam id_t LAST_ID = id_t'(NUM_BUFFERS - 1);

  function automatic id_t next_id(input id_t id);
    return (id == LAST_ID) ? '0 : id + id_t'(1);
  endfunction

  logic [1:0] buf_state_q [NUM_BUFFERS];
  logic [1:0] buf_state_d [NUM_BUFFERS];
  id_t        q_mem_q     [NUM_BUFFERS];
  id_t        q_mem_d     [NUM_BUFFERS];
  id_t        head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;
  logic [1:0] w_state_q, w_state_d, r_state_q, r_state_d;
  id_t        wr_id_q, wr_id_d, rd_id_q, rd_id_d;
  id_t        search_ptr_q, search_ptr_d;
  logic       dropped_q, dropped_d, perr_q, perr_d;

  logic free_found;
  id_t  free_id, cand;
  logic rd_pop, wr_try, wr_take_free, wr_reclaim, wr_push, rd_release;
  id_t  head_next, reclaim_id;

  // Round-robin search for a FREE buffer, starting at the write search pointer.
  always_comb begin
    // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
    free_found = 1'b0;
    free_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_BUFFERS; k++) begin
      cand = id_t'((int'(search_ptr_q) + k) % NUM_BUFFERS);
      if (!free_found && buf_state_q[cand] == B_FREE) begin
        free_found = 1'b1;
        free_id    = cand;
      end
    end
  end

  // The reader always wins the queue head; a same-cycle reclaim takes the entry behind it.
  assign rd_pop       = (r_state_q == R_IDLE) && bus.read_rq_rdy && (count_q != '0);
  assign wr_try       = (w_state_q == W_IDLE) && bus.write_rq_rdy;
  assign wr_take_free = wr_try && free_found;
  assign wr_reclaim   = DROP_ON_FULL && wr_try && !free_found && (count_q > cnt_t'(rd_pop));
  assign wr_push      = bus.finalize_wr && (w_state_q == W_HOLD);
  assign rd_release   = bus.finalize_rd && (r_state_q == R_HOLD);
  assign head_next    = next_id(head_q);
  assign reclaim_id   = rd_pop ? q_mem_q[head_next] : q_mem_q[head_q];

  always_comb begin
    buf_state_d  = buf_state_q;
    q_mem_d      = q_mem_q;
    tail_d       = tail_q;
    w_state_d    = w_state_q;
    r_state_d    = r_state_q;
    wr_id_d      = wr_id_q;
    rd_id_d      = rd_id_q;
    search_ptr_d = search_ptr_q;
    dropped_d    = wr_reclaim;
    perr_d       = (bus.finalize_wr && (w_state_q != W_HOLD)) ||
                   (bus.finalize_rd && (r_state_q != R_HOLD));
    count_d      = count_q + cnt_t'(wr_push) - cnt_t'(rd_pop) - cnt_t'(wr_reclaim);

    case ({rd_pop, wr_reclaim})
      2'b11:        head_d = next_id(head_next);
      2'b10, 2'b01: head_d = head_next;
      default:      head_d = head_q;
    endcase

    case (w_state_q)
      W_IDLE: begin
        if (wr_take_free) begin
          wr_id_d              = free_id;
          search_ptr_d         = next_id(free_id);
          buf_state_d[free_id] = B_WRITING;
          w_state_d            = W_GRANT;
        end else if (wr_reclaim) begin
          wr_id_d                 = reclaim_id;
          buf_state_d[reclaim_id] = B_WRITING;
          w_state_d               = W_GRANT;
        end
      end
      W_GRANT: if (!bus.write_rq_rdy) w_state_d = W_HOLD;
      W_HOLD: begin
        if (wr_push) begin
          buf_state_d[wr_id_q] = B_READY;
          q_mem_d[tail_q]      = wr_id_q;
          tail_d               = next_id(tail_q);
          w_state_d            = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    case (r_state_q)
      R_IDLE: begin
        if (rd_pop) begin
          rd_id_d                      = q_mem_q[head_q];
          buf_state_d[q_mem_q[head_q]] = B_READING;
          r_state_d                    = R_GRANT;
        end
      end
      R_GRANT: if (!bus.read_rq_rdy) r_state_d = R_HOLD;
      R_HOLD: begin
        if (rd_release) begin
          buf_state_d[rd_id_q] = B_FREE;
          r_state_d            = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the queue storage is reset too, because entry 0 must hold buffer 0 out of reset.
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_state_q[i] <= (i == 0) ? B_READY : B_FREE;
        q_mem_q[i]     <= '0;
      end
      head_q       <= '0;
      tail_q       <= next_id('0);
      count_q      <= cnt_t'(1);
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_id_q      <= '0;
      rd_id_q      <= '0;
      search_ptr_q <= id_t'(1);
      dropped_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      buf_state_q  <= buf_state_d;
      q_mem_q      <= q_mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_id_q      <= wr_id_d;
      rd_id_q      <= rd_id_d;
      search_ptr_q <= search_ptr_d;
      dropped_q    <= dropped_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.wr_id_valid    = (w_state_q == W_GRANT);
  assign bus.wr_id          = wr_id_q;
  assign bus.rd_id_valid    = (r_state_q == R_GRANT);
  assign bus.rd_id          = rd_id_q;
  assign bus.ready_count    = count_q;
  assign bus.frame_dropped  = dropped_q;
  assign bus.protocol_error = perr_q;

endmodule

// File: tb/tb_multi_buffer_controller.sv
// Directed bench for multi_buffer_controller: three instances (N=3 drop, N=3 stall, N=4 drop)
// driven on the falling edge and sampled on the falling edge after each rising edge.
module tb_multi_buffer_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0] wr_rq, fin_wr, rd_rq, fin_rd;
  logic [2:0] wr_valid, rd_valid, dropped, perr;
  logic [1:0] wr_id [3];
  logic [1:0] rd_id [3];
  logic [2:0] cnt   [3];

  int n_checks = 0;
  int n_pass   = 0;

  multi_buffer_controller_if #(.ID_WIDTH(2)) if0 ();
  multi_buffer_controller_if #(.ID_WIDTH(2)) if1 ();
  multi_buffer_controller_if #(.ID_WIDTH(2)) if2 ();

  multi_buffer_controller #(.NUM_BUFFERS(3), .DROP_ON_FULL(1'b1)) u_drop (
    .clk(clk), .reset(reset), .bus(if0));
  multi_buffer_controller #(.NUM_BUFFERS(3), .DROP_ON_FULL(1'b0)) u_stall (
    .clk(clk), .reset(reset), .bus(if1));
  multi_buffer_controller #(.NUM_BUFFERS(4), .DROP_ON_FULL(1'b1)) u_four (
    .clk(clk), .reset(reset), .bus(if2));

  assign if0.write_rq_rdy = wr_rq[0];
  assign if0.finalize_wr  = fin_wr[0];
  assign if0.read_rq_rdy  = rd_rq[0];
  assign if0.finalize_rd  = fin_rd[0];
  assign if1.write_rq_rdy = wr_rq[1];
  assign if1.finalize_wr  = fin_wr[1];
  assign if1.read_rq_rdy  = rd_rq[1];
  assign if1.finalize_rd  = fin_rd[1];
  assign if2.write_rq_rdy = wr_rq[2];
  assign if2.finalize_wr  = fin_wr[2];
  assign if2.read_rq_rdy  = rd_rq[2];
  assign if2.finalize_rd  = fin_rd[2];

  assign wr_valid = {if2.wr_id_valid, if1.wr_id_valid, if0.wr_id_valid};
  assign rd_valid = {if2.rd_id_valid, if1.rd_id_valid, if0.rd_id_valid};
  assign dropped  = {if2.frame_dropped, if1.frame_dropped, if0.frame_dropped};
  assign perr     = {if2.protocol_error, if1.protocol_error, if0.protocol_error};
  assign wr_id[0] = if0.wr_id;
  assign wr_id[1] = if1.wr_id;
  assign wr_id[2] = if2.wr_id;
  assign rd_id[0] = if0.rd_id;
  assign rd_id[1] = if1.rd_id;
  assign rd_id[2] = if2.rd_id;
  assign cnt[0]   = if0.ready_count;
  assign cnt[1]   = if1.ready_count;
  assign cnt[2]   = if2.ready_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Full write transaction: request, grant, drop request, finalize.
  task automatic write_cycle(input int d, input int exp_id, input bit exp_drop, input int exp_cnt);
    wr_rq[d] = 1'b1;
    tick();
    check($sformatf("d%0d wr_valid grant", d), wr_valid[d], 1);
    check($sformatf("d%0d wr_id grant", d), wr_id[d], exp_id);
    check($sformatf("d%0d frame_dropped", d), dropped[d], exp_drop);
    check($sformatf("d%0d ready_count at wr grant", d), cnt[d], exp_cnt);
    wr_rq[d] = 1'b0;
    tick();
    check($sformatf("d%0d wr_valid after rq low", d), wr_valid[d], 0);
    check($sformatf("d%0d wr_id held", d), wr_id[d], exp_id);
    fin_wr[d] = 1'b1;
    tick();
    fin_wr[d] = 1'b0;
  endtask

  task automatic read_cycle(input int d, input int exp_id, input int exp_cnt);
    rd_rq[d] = 1'b1;
    tick();
    check($sformatf("d%0d rd_valid grant", d), rd_valid[d], 1);
    check($sformatf("d%0d rd_id grant", d), rd_id[d], exp_id);
    check($sformatf("d%0d ready_count after pop", d), cnt[d], exp_cnt);
    rd_rq[d] = 1'b0;
    tick();
    check($sformatf("d%0d rd_valid after rq low", d), rd_valid[d], 0);
    check($sformatf("d%0d rd_id held", d), rd_id[d], exp_id);
    fin_rd[d] = 1'b1;
    tick();
    fin_rd[d] = 1'b0;
  endtask

  initial begin
    wr_rq = '0; fin_wr = '0; rd_rq = '0; fin_rd = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;

    // Reset state on every instance.
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset ready_count", d), cnt[d], 1);
      check($sformatf("d%0d reset wr_valid", d), wr_valid[d], 0);
      check($sformatf("d%0d reset rd_valid", d), rd_valid[d], 0);
      check($sformatf("d%0d reset wr_id", d), wr_id[d], 0);
      check($sformatf("d%0d reset frame_dropped", d), dropped[d], 0);
      check($sformatf("d%0d reset protocol_error", d), perr[d], 0);
    end

    // N=3 with reclaim, writer only: ids 1,2,0,1,2,0,1,2,0,1; drops from the 3rd grant.
    begin
      int exp_ids [10] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
      for (int i = 0; i < 10; i++)
        write_cycle(0, exp_ids[i], (i >= 2), (i == 0) ? 1 : 2);
    end
    check("d0 ready_count after writer loop", cnt[0], 3);

    // N=3 stall: grants 1,2 then the writer waits until the reader frees buffer 0.
    write_cycle(1, 1, 1'b0, 1);
    write_cycle(1, 2, 1'b0, 2);
    wr_rq[1] = 1'b1;
    tick(3);
    check("d1 stall wr_valid", wr_valid[1], 0);
    check("d1 stall frame_dropped", dropped[1], 0);
    rd_rq[1] = 1'b1;
    tick();
    check("d1 rd_valid", rd_valid[1], 1);
    check("d1 rd_id", rd_id[1], 0);
    check("d1 ready_count after pop", cnt[1], 2);
    rd_rq[1] = 1'b0;
    tick();
    fin_rd[1] = 1'b1;
    tick();
    fin_rd[1] = 1'b0;
    check("d1 no grant on finalize edge", wr_valid[1], 0);
    tick();
    check("d1 wr_valid after release", wr_valid[1], 1);
    check("d1 wr_id after release", wr_id[1], 0);
    wr_rq[1] = 1'b0;
    tick();
    fin_wr[1] = 1'b1;
    tick();
    fin_wr[1] = 1'b0;
    check("d1 ready_count after refill", cnt[1], 3);

    // Illegal finalizes on idle channels: error pulse, no state change.
    fin_wr[1] = 1'b1;
    tick();
    fin_wr[1] = 1'b0;
    check("d1 perr on idle finalize_wr", perr[1], 1);
    check("d1 count unchanged after bad finalize_wr", cnt[1], 3);
    tick();
    check("d1 perr one cycle (wr)", perr[1], 0);
    fin_rd[1] = 1'b1;
    tick();
    fin_rd[1] = 1'b0;
    check("d1 perr on idle finalize_rd", perr[1], 1);
    check("d1 count unchanged after bad finalize_rd", cnt[1], 3);
    tick();
    check("d1 perr one cycle (rd)", perr[1], 0);
    read_cycle(1, 1, 2);

    // N=4: writes 1,2,3 then reads follow completion order 0,1,2,3.
    write_cycle(2, 1, 1'b0, 1);
    write_cycle(2, 2, 1'b0, 2);
    write_cycle(2, 3, 1'b0, 3);
    check("d2 ready_count full", cnt[2], 4);
    read_cycle(2, 0, 3);
    read_cycle(2, 1, 2);
    read_cycle(2, 2, 1);
    read_cycle(2, 3, 0);
    rd_rq[2] = 1'b1;
    tick(3);
    check("d2 empty queue read waits", rd_valid[2], 0);
    rd_rq[2] = 1'b0;
    tick();

    // Same-cycle reader pop and writer reclaim on queue [2,0,1].
    wr_rq[0] = 1'b1;
    rd_rq[0] = 1'b1;
    tick();
    check("d0 collide rd_id", rd_id[0], 2);
    check("d0 collide wr_id", wr_id[0], 0);
    check("d0 collide both valid", {wr_valid[0], rd_valid[0]}, 2'b11);
    check("d0 collide ids distinct", (wr_id[0] != rd_id[0]), 1);
    check("d0 collide frame_dropped", dropped[0], 1);
    check("d0 collide ready_count", cnt[0], 1);
    wr_rq[0] = 1'b0;
    rd_rq[0] = 1'b0;
    tick();
    fin_wr[0] = 1'b1;
    fin_rd[0] = 1'b1;
    tick();
    fin_wr[0] = 1'b0;
    fin_rd[0] = 1'b0;
    check("d0 ready_count after collide release", cnt[0], 2);

    // Reset while both channels hold a grant.
    wr_rq[0] = 1'b1;
    rd_rq[0] = 1'b1;
    tick();
    check("d0 pre-reset wr_id", wr_id[0], 2);
    check("d0 pre-reset rd_id", rd_id[0], 1);
    check("d0 pre-reset valids", {wr_valid[0], rd_valid[0]}, 2'b11);
    reset    = 1'b1;
    wr_rq[0] = 1'b0;
    rd_rq[0] = 1'b0;
    tick();
    reset = 1'b0;
    check("d0 wr_valid after reset", wr_valid[0], 0);
    check("d0 rd_valid after reset", rd_valid[0], 0);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d ready_count after reset", d), cnt[d], 1);
    wr_rq[0] = 1'b1;
    tick();
    check("d0 first grant after reset valid", wr_valid[0], 1);
    check("d0 first grant after reset id", wr_id[0], 1);
    wr_rq[0] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
